radix4_partial_product_accumulator: RTL and testbench
=====================================================

// Module: radix4_partial_product_accumulator
// PURPOSE
//   Downstream consumer of the serial radix-4 recoder. Accepts one signed
//   Booth digit per beat, LSB-first, from the recoder's answering phase.
//   Forms x*d, shifts it by 2*i and accumulates it into x*y.
//   Returns the full signed product over a valid/ready handshake.
// PARAMETERS
//   X_WIDTH  8  width of signed multiplicand x
//   Y_WIDTH  8  width of signed multiplier y; digit count N = (Y_WIDTH+2)/2 (int div)
// PORTS
//   clk            in   1                clock
//   rst            in   1                reset
//   start          in   1                launch transaction; samples x_in (IDLE only)
//   x_in           in   X_WIDTH          signed multiplicand
//   digit_valid    in   1                digit beat present
//   digit          in   3                two's-complement Booth digit, legal -2..+2
//   digit_ready    out  1                accepting digits (state==COLLECT)
//   busy           out  1                state != IDLE
//   product_valid  out  1                product held (state==HOLD)
//   product        out  X_WIDTH+Y_WIDTH  signed x*y
//   product_ready  in   1                consumer accepts product
//   digit_err      out  1                only with RADIX4_ILLEGAL_DIGIT_CHECK_EN
// BEHAVIOUR
//   Reset: rst, asynchronous, active-high; clock clk. On rst: state=IDLE, x_reg=0,
//     acc=0, cnt=0, and all outputs 0 (digit_err too, if present).
//   FSM: IDLE -start-> COLLECT -Nth digit accepted-> HOLD -product_ready-> IDLE.
//   IDLE: start=1 latches x_in and clears acc, cnt and digit_err. COLLECT follows next cycle.
//   COLLECT: digit_ready=1. A beat is accepted when digit_valid&&digit_ready.
//     On accept: acc <= acc + (sext(x_reg)*digit) << 2*cnt; cnt <= cnt+1.
//     Accepting digit N-1 enters HOLD. Gaps in digit_valid stall with no change.
//   acc width is X_WIDTH+Y_WIDTH+2 and wraps modulo 2^width.
//     product = acc[X_WIDTH+Y_WIDTH-1:0]. This is exact for all legal inputs.
//   Partial product uses shift/negate only (0, +-x, +-2x), no multiplier.
//   HOLD: product_valid=1. product stays stable until product_ready=1.
//     The handshake cycle returns to IDLE, and product_valid drops the next cycle.
//   Latency: product_valid rises 1 cycle after the last digit is accepted.
//     Minimum start-to-valid time is N+1 cycles.
//   start outside IDLE is ignored, including start coincident with product_ready in HOLD.
//   digit_valid outside COLLECT is ignored.
//   Illegal codes 3'b011, 3'b100, 3'b101 decode as digit 0.
//   rst mid-transaction aborts it immediately. No partial product is emitted.
// CONFIGURATION
//   RADIX4_ILLEGAL_DIGIT_CHECK_EN defined:
//     - adds port digit_err.
//     - An accepted illegal code sets digit_err sticky.
//     - digit_err is cleared by start in IDLE or by rst. The product is still produced (digit=0).
//   Undefined: the port is absent and illegal codes are silently decoded as 0.
// TESTING (X_WIDTH=8, Y_WIDTH=8, N=5)
//   x=5, digits [-1,+2,0,0,0] back-to-back -> product=16'h0023, valid 6 cycles after start.
//   x=-128, digits [0,0,0,-2,0] -> product=16'h4000 (x*y = -128*-128).
//   Same as case 1, with digit_valid low for 3 cycles between beats -> same product.
//     cnt must not advance during gaps.
//   HOLD with product_ready low for 10 cycles, plus start pulses -> product and valid stable.
//     start is ignored.
//   rst pulse after 2 of 5 digits -> all outputs 0 and IDLE.
//     The next full transaction (x=3, digits [1,0,0,0,0]) -> product=16'h0003.
//   With EN: x=7, digits [3'b011,0,0,0,0] -> digit_err=1, product=0.
//     The next start clears digit_err.

Source files
------------

// File: rtl/radix4_partial_product_accumulator_if.sv
// Digit-in / product-out bus between the radix-4 recoder, the accumulator and the product consumer.
// Optional RADIX4_ILLEGAL_DIGIT_CHECK_EN adds the sticky digit_err status line.
interface radix4_partial_product_accumulator_if #(
  parameter int unsigned X_WIDTH = 8,
  parameter int unsigned Y_WIDTH = 8
);
  logic                       start;
  logic [X_WIDTH-1:0]         x_in;
  logic                       digit_valid;
  logic [2:0]                 digit;
  logic                       digit_ready;
  logic                       busy;
  logic                       product_valid;
  logic [X_WIDTH+Y_WIDTH-1:0] product;
  logic                       product_ready;
`ifdef RADIX4_ILLEGAL_DIGIT_CHECK_EN
  logic                       digit_err;

  modport master (
    output start, x_in, digit_valid, digit, product_ready,
    input  digit_ready, busy, product_valid, product, digit_err
  );
  modport slave (
    input  start, x_in, digit_valid, digit, product_ready,
    output digit_ready, busy, product_valid, product, digit_err
  );
`else
  modport master (
    output start, x_in, digit_valid, digit, product_ready,
    input  digit_ready, busy, product_valid, product
  );
  modport slave (
    input  start, x_in, digit_valid, digit, product_ready,
    output digit_ready, busy, product_valid, product
  );
`endif
endinterface

// File: rtl/radix4_partial_product_accumulator.sv
// Serial radix-4 Booth partial-product accumulator: takes one signed digit per beat (LSB first),
// adds x*d << 2*i into an accumulator and hands back the signed product x*y.
// Optional macro RADIX4_ILLEGAL_DIGIT_CHECK_EN: flags accepted illegal digit codes on digit_err.
module radix4_partial_product_accumulator #(
  parameter int unsigned X_WIDTH = 8,
  parameter int unsigned Y_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  radix4_partial_product_accumulator_if.slave   bus_io
);

  localparam int unsigned N    = (Y_WIDTH + 2) / 2;
  localparam int unsigned PW   = X_WIDTH + Y_WIDTH;
  localparam int unsigned AccW = PW + 2;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  state_e             state_q, state_d;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [AccW-1:0]    x_ext;
  logic [AccW-1:0]    pp;
  logic [AccW-1:0]    pp_shift;
  logic               accept;

  // The top two accumulator bits only exist so the running sum cannot overflow mid-way.
  logic unused_acc_msbs;
  assign unused_acc_msbs = ^acc_q[AccW-1:PW];

  assign accept = (state_q == StCollect) && bus_io.digit_valid;

  // Partial product from shift/negate of the sign-extended multiplicand; illegal codes give 0.
  always_comb begin
    x_ext = {{(AccW - X_WIDTH){x_q[X_WIDTH-1]}}, x_q};
    pp    = '0;
    case (bus_io.digit)
      3'b001:  pp = x_ext;
      3'b010:  pp = x_ext << 1;
      3'b111:  pp = -x_ext;
      3'b110:  pp = -(x_ext << 1);
      default: pp = '0;
    endcase
    pp_shift = pp << {cnt_q, 1'b0};
  end

`ifdef RADIX4_ILLEGAL_DIGIT_CHECK_EN
  logic err_q, err_d;
  logic digit_illegal;

  assign digit_illegal = (bus_io.digit == 3'b011) || (bus_io.digit == 3'b100) ||
                         (bus_io.digit == 3'b101);
  assign bus_io.digit_err = err_q;
`endif

  // Next-state logic: launch, per-digit accumulate, and product hand-off.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef RADIX4_ILLEGAL_DIGIT_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          x_d     = bus_io.x_in;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef RADIX4_ILLEGAL_DIGIT_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (accept) begin
          acc_d = acc_q + pp_shift;
          cnt_d = cnt_q + CntW'(1);
`ifdef RADIX4_ILLEGAL_DIGIT_CHECK_EN
          if (digit_illegal) err_d = 1'b1;
`endif
          if (cnt_q == LastCnt) state_d = StHold;
        end
      end
      StHold: begin
        if (bus_io.product_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; rst aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef RADIX4_ILLEGAL_DIGIT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef RADIX4_ILLEGAL_DIGIT_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus_io.digit_ready   = (state_q == StCollect);
  assign bus_io.busy          = (state_q != StIdle);
  assign bus_io.product_valid = (state_q == StHold);
  assign bus_io.product       = acc_q[PW-1:0];

endmodule

// File: tb/tb_radix4_partial_product_accumulator.sv
// Scoreboard bench for the radix-4 partial-product accumulator (X_WIDTH=8, Y_WIDTH=8, N=5).
module tb_radix4_partial_product_accumulator;

  localparam int XW = 8;
  localparam int YW = 8;
  localparam int N  = (YW + 2) / 2;
  localparam int PW = XW + YW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  radix4_partial_product_accumulator_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

  radix4_partial_product_accumulator #(.X_WIDTH(XW), .Y_WIDTH(YW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [PW-1:0] exp_q[$];
  logic [2:0] dg [N];
  logic [2:0] legal_codes [5];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int digit_val(input logic [2:0] c);
    case (c)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b110:  return -2;
      3'b111:  return -1;
      default: return 0;
    endcase
  endfunction

  function automatic bit digit_bad(input logic [2:0] c);
    return (c == 3'b011) || (c == 3'b100) || (c == 3'b101);
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic run_txn(input logic [XW-1:0] x, input logic [2:0] codes [N], input int gap,
                         input int hold, input bit start_pulses);
    int   exp_i;
    int   lat;
    int   w;
    bit   err_exp;
    logic [PW-1:0] prod_exp;
    exp_i   = 0;
    err_exp = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_i   += int'($signed(x)) * digit_val(codes[i]) * (1 << (2 * i));
      err_exp |= digit_bad(codes[i]);
    end
    prod_exp = exp_i[PW-1:0];
    exp_q.push_back(prod_exp);

    bus.start = 1'b1;
    bus.x_in  = x;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.x_in  = ~x;
    lat = 1;
    check_eq("busy_after_start", 32'(bus.busy), 32'd1);
`ifdef RADIX4_ILLEGAL_DIGIT_CHECK_EN
    check_eq("err_cleared_by_start", 32'(bus.digit_err), 32'd0);
`endif
    for (int i = 0; i < N; i++) begin
      bus.digit_valid = 1'b1;
      bus.digit       = codes[i];
      check_eq("digit_ready", 32'(bus.digit_ready), 32'd1);
      @(posedge clk); #1;
      lat++;
      bus.digit_valid = 1'b0;
      bus.digit       = 3'b010;
      if (i != N - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          lat++;
        end
      end
    end
    w = 0;
    while (!bus.product_valid && w < 20) begin
      @(posedge clk); #1;
      lat++;
      w++;
    end
    check_eq("product_valid", 32'(bus.product_valid), 32'd1);
    if (gap == 0) check_eq("latency", 32'(lat), 32'(N + 1));

    for (int h = 0; h < hold; h++) begin
      bus.product_ready = 1'b0;
      bus.start         = start_pulses ? 1'(h % 2) : 1'b0;
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(bus.product_valid), 32'd1);
      check_eq("hold_product", 32'(bus.product), 32'(exp_q[0]));
    end
    bus.start         = start_pulses;
    bus.product_ready = 1'b1;
    check_eq("product", 32'(bus.product), 32'(exp_q.pop_front()));
`ifdef RADIX4_ILLEGAL_DIGIT_CHECK_EN
    check_eq("digit_err", 32'(bus.digit_err), 32'(err_exp));
`endif
    @(posedge clk); #1;
    bus.start         = 1'b0;
    bus.product_ready = 1'b0;
    check_eq("valid_drop", 32'(bus.product_valid), 32'd0);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    legal_codes = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.x_in          = '0;
    bus.digit_valid   = 1'b0;
    bus.digit         = '0;
    bus.product_ready = 1'b0;
    #12;
    check_eq("rst_product", 32'(bus.product), 32'd0);
    check_eq("rst_valid", 32'(bus.product_valid), 32'd0);
    check_eq("rst_ready", 32'(bus.digit_ready), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // x=5, digits [-1,+2,0,0,0] back-to-back -> 0x0023
    dg = '{3'b111, 3'b010, 3'b000, 3'b000, 3'b000};
    run_txn(8'd5, dg, 0, 0, 1'b0);

    // x=-128, digits [0,0,0,-2,0] -> 0x4000
    dg = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b000};
    run_txn(8'h80, dg, 0, 1, 1'b0);

    // Same as the first case with 3-cycle gaps between beats.
    dg = '{3'b111, 3'b010, 3'b000, 3'b000, 3'b000};
    run_txn(8'd5, dg, 3, 0, 1'b0);

    // Long HOLD with start pulses, including start on the handshake cycle.
    dg = '{3'b001, 3'b110, 3'b111, 3'b010, 3'b001};
    run_txn(8'h9b, dg, 0, 10, 1'b1);

    // Abort after 2 of 5 digits.
    bus.start = 1'b1;
    bus.x_in  = 8'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.digit_valid = 1'b1;
      bus.digit       = 3'b001;
      @(posedge clk); #1;
    end
    bus.digit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("abort_product", 32'(bus.product), 32'd0);
    check_eq("abort_valid", 32'(bus.product_valid), 32'd0);
    check_eq("abort_ready", 32'(bus.digit_ready), 32'd0);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dg = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    run_txn(8'd3, dg, 0, 0, 1'b0);

    // Illegal code decodes as 0 (and raises digit_err when the check is built in).
    dg = '{3'b011, 3'b000, 3'b000, 3'b000, 3'b000};
    run_txn(8'd7, dg, 0, 0, 1'b0);
    dg = '{3'b100, 3'b001, 3'b101, 3'b000, 3'b000};
    run_txn(8'd7, dg, 1, 0, 1'b0);

    // Random legal transactions.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) dg[i] = legal_codes[$urandom_range(0, 4)];
      run_txn(8'($urandom), dg, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    end

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
